// File: rtl/daq_trig_pkg.sv
// Shared types and constants for the DAQ trigger responder.
package daq_trig_pkg;

    // Acquisition sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StCapture,
        StReadout,
        StHoldoff
    } state_e;

    // Clocks spent low after readout; at least 4 so the divider's 3-flop sync sees a clean edge.
    localparam int unsigned HoldoffDefault = 16;

    // Width of the overrun counter.
    localparam int unsigned OvrCntW = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import daq_trig_pkg::*;
#(
    parameter int unsigned WIDTH = OvrCntW
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/daq_trig_responder.sv
// Receiving end of the divider->DAQ trigger handshake: arm delay, capture window,
// readout request and holdoff before re-enabling the divider's trigger path.
module daq_trig_responder
    import daq_trig_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DLY_W   = 8,
    parameter int unsigned HOLDOFF = HoldoffDefault,
    parameter int unsigned TAG_W   = 6
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               trig_in,
    input  logic               strb_in,
    input  logic [TAG_W-1:0]   tag_in,
    input  logic               run,
    input  logic [DLY_W-1:0]   arm_dly,
    input  logic [ADDR_W-1:0]  win_len,
    input  logic               rd_ack,
    output logic               trig_rdy,
    output logic               cap_en,
    output logic [ADDR_W-1:0]  cap_addr,
    output logic               rd_req,
    output logic [TAG_W-1:0]   tag_out,
    output logic               strb_out,
    output logic [OvrCntW-1:0] ovr_cnt,
    output logic               abort
);

    localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_e            state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              strb_q, strb_d;
    logic              abort_q, abort_d;
    logic              trig_rdy_q, trig_rdy_d;
    logic              cap_en_q, cap_en_d;
    logic              rd_req_q, rd_req_d;
    logic              ovr_inc;

    // Any trigger seen outside IDLE is an overrun, whatever else happens this clock.
    assign ovr_inc = trig_in && (state_q != StIdle);

    // Sequencer next state; registered outputs are decoded from the next state.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        len_d   = len_q;
        tag_d   = tag_q;
        strb_d  = strb_q;
        abort_d = abort_q;

        if (!run && (state_q != StIdle)) begin
            // Losing run while data is in flight leaves a sticky abort flag.
            if (state_q != StHoldoff) begin
                abort_d = 1'b1;
            end
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (trig_in && run) begin
                        tag_d   = tag_in;
                        strb_d  = strb_in;
                        abort_d = 1'b0;
                        addr_d  = '0;
                        len_d   = win_len;
                        if (arm_dly == '0) begin
                            state_d = StCapture;
                        end else begin
                            dly_d   = arm_dly;
                            state_d = StDelay;
                        end
                    end
                end
                StDelay: begin
                    if (dly_q == DLY_W'(1)) begin
                        state_d = StCapture;
                    end else begin
                        dly_d = dly_q - 1'b1;
                    end
                end
                StCapture: begin
                    // Address holds its last value once the window closes.
                    if (addr_q == len_q) begin
                        state_d = StReadout;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                StReadout: begin
                    if (rd_ack) begin
                        hold_d  = HoldW'(HOLDOFF - 1);
                        state_d = StHoldoff;
                    end
                end
                StHoldoff: begin
                    if (hold_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        trig_rdy_d = (state_d == StIdle) && run;
        cap_en_d   = (state_d == StCapture);
        rd_req_d   = (state_d == StReadout);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= StIdle;
            dly_q      <= '0;
            hold_q     <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            tag_q      <= '0;
            strb_q     <= 1'b0;
            abort_q    <= 1'b0;
            trig_rdy_q <= 1'b0;
            cap_en_q   <= 1'b0;
            rd_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            hold_q     <= hold_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            tag_q      <= tag_d;
            strb_q     <= strb_d;
            abort_q    <= abort_d;
            trig_rdy_q <= trig_rdy_d;
            cap_en_q   <= cap_en_d;
            rd_req_q   <= rd_req_d;
        end
    end

    sat_counter #(
        .WIDTH(OvrCntW)
    ) u_ovr_cnt (
        .clk  (clk),
        .rst_b(rst_b),
        .inc  (ovr_inc),
        .clr  (1'b0),
        .count(ovr_cnt)
    );

    assign trig_rdy = trig_rdy_q;
    assign cap_en   = cap_en_q;
    assign cap_addr = addr_q;
    assign rd_req   = rd_req_q;
    assign tag_out  = tag_q;
    assign strb_out = strb_q;
    assign abort    = abort_q;

endmodule

// File: doc/daq_trig_responder.md
Name: daq_trig_responder

Overview:
- Receiving end of the divider→DAQ trigger handshake.
- Accepts the single-cycle DAQ trigger pulse, applies a programmable arm delay, then gates a fixed-length sample capture window into the DAQ buffer.
- Issues a readout request to the UART-side reader and waits for completion.
- Returns the level `trig_rdy`; its rising edge re-enables the divider's blocked trigger path.

Parameters:
- ADDR_W, 9, width of capture address and window length (max window 2^ADDR_W samples).
- DLY_W, 8, width of arm-delay counter.
- HOLDOFF, 16, clocks spent low after readout before `trig_rdy` rises (≥ 4 so the divider's 3-flop sync sees a clean edge).
- TAG_W, 6, width of pulse-counter tag.

Ports:
- clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- trig_in  in  1  single-cycle DAQ trigger pulse, clk-synchronous
- strb_in  in  1  coincident with trig_in; 1 = selected-sequence (real data) trigger
- tag_in  in  TAG_W  pulse counter value at trigger
- run  in  1  acquisition enable, already synchronised
- arm_dly  in  DLY_W  clocks from trigger to window open
- win_len  in  ADDR_W  samples per window minus 1
- rd_ack  in  1  single-cycle pulse: reader finished draining buffer
- trig_rdy  out  1  high only in IDLE
- cap_en  out  1  buffer write enable during window
- cap_addr  out  ADDR_W  buffer write address
- rd_req  out  1  level, high in READOUT until rd_ack
- tag_out  out  TAG_W  tag latched at accepted trigger
- strb_out  out  1  strb_in latched at accepted trigger
- ovr_cnt  out  8  triggers received while not IDLE, saturating
- abort  out  1  sticky: run dropped mid-acquisition; cleared on next accepted trigger

Behaviour:
- Reset (async, rst_b=0): state IDLE, trig_rdy=0, cap_en=0, cap_addr=0, rd_req=0, tag_out=0, strb_out=0, ovr_cnt=0, abort=0.
- trig_rdy is registered and rises on the first clk after reset release when run=1; held low while run=0.
- States:
  - IDLE: trig_rdy=1. On trig_in & run: latch tag_in/strb_in, clear abort, load delay counter with arm_dly, go to DELAY (or CAPTURE directly if arm_dly=0). trig_rdy=0 on the next clk.
  - DELAY: decrement each clk; at 1 → CAPTURE next clk. Trigger to first cap_en = arm_dly+1 clks; arm_dly=0 gives 1 clk.
  - CAPTURE: cap_en=1, cap_addr starts 0 and increments each clk. Exactly win_len+1 writes; after the cap_addr==win_len write → READOUT. cap_addr holds the last value afterwards and resets to 0 on the next accepted trigger.
  - READOUT: rd_req=1 until rd_ack sampled high; then rd_req=0 → HOLDOFF. rd_ack outside READOUT is ignored.
  - HOLDOFF: count HOLDOFF clks, then IDLE.
- Overrun: trig_in in any state other than IDLE (including the last HOLDOFF clk) increments ovr_cnt, saturating at 255, and is otherwise ignored. Only IDLE accepts triggers.
- run=0 in DELAY/CAPTURE/READOUT/HOLDOFF: abort set if state was DELAY, CAPTURE or READOUT; cap_en and rd_req drop next clk; state → IDLE. trig_rdy stays 0 while run=0.
- run=0 in IDLE: triggers ignored, not counted as overrun.
- trig_in and rd_ack never coincide meaningfully; if trig_in arrives the same clk READOUT completes, it is counted as an overrun.
- All outputs registered; no combinational input→output paths.

Decomposition:
- Shared package daq_trig_pkg: state enum (IDLE, DELAY, CAPTURE, READOUT, HOLDOFF), HOLDOFF default, ovr_cnt width constant.
- One natural sub-module: sat_counter (width param, inc, clr, saturating), used for ovr_cnt. FSM and address counter stay in the top.

Test Plan:
- Basic: run=1, arm_dly=3, win_len=7, trig_in pulse with tag_in=0x15, strb_in=1 → trig_rdy low next clk; cap_en high clks 4–11 after trigger with cap_addr 0..7; rd_req rises the clk after; tag_out=0x15, strb_out=1.
- Readout/holdoff: rd_ack pulse 20 clks into READOUT → rd_req falls next clk; trig_rdy rises exactly HOLDOFF(16)+1 clks after rd_ack.
- Overrun: 300 trig_in pulses during CAPTURE/READOUT → ovr_cnt=255 (saturated); cap_addr sequence unaffected; next trigger in IDLE is accepted normally.
- Abort: drop run at cap_addr=3 → cap_en=0 next clk; abort=1; trig_rdy stays 0 until run=1, then 1; next accepted trigger clears abort.
- Edges: arm_dly=0 → cap_en the clk after trigger; win_len=0 → single write at addr 0; trig_in on the final HOLDOFF clk → ignored, ovr_cnt +1.
- Async reset mid-CAPTURE: rst_b low between clk edges → all outputs return to reset values immediately, trig_rdy=0; after release with run=1, trig_rdy=1 on the next clk.
